// File: rtl/io_timer_pkg.sv
// Shared definitions for the io_timer peripheral: bus geometry defaults,
// register indices, CTRL/STATUS bit positions and the bus FSM state type.
package io_timer_pkg;

    localparam int PERIPH_DATA_WIDTH = 32;
    localparam int PERIPH_ADDR_WIDTH = 4;

    // Register indices as seen after the slot has rebased the address
    localparam int TIMER_CTRL   = 0;
    localparam int TIMER_LOAD   = 1;
    localparam int TIMER_COUNT  = 2;
    localparam int TIMER_STATUS = 3;

    // CTRL field positions
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_AUTO_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;
    localparam int CTRL_PRESC_LSB   = 8;
    localparam int CTRL_PRESC_WIDTH = 8;

    // STATUS field positions
    localparam int STATUS_EXPIRED_BIT = 0;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/io_timer_periph_bus_if.sv
// Reusable peripheral bus slave: IDLE/ACK handshake, one-shot access strobes
// toward the register file, read capture buffer and the tristate data driver.
module io_timer_periph_bus_if
    import io_timer_pkg::*;
#(
    parameter int DATA_WIDTH = PERIPH_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_read,
    input  logic                  io_write,
    inout  wire  [DATA_WIDTH-1:0] io_data,
    output logic                  io_ready,
    output logic                  o_wr_strobe,
    output logic                  o_rd_strobe,
    input  logic [DATA_WIDTH-1:0] i_rd_data
);

    bus_state_e            r_state;
    bus_state_e            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_rd_buf;
    logic                  w_req;
    logic                  w_drive;

    assign w_req = io_read | io_write;

    // Bus FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; strobes fire only on the IDLE->ACK edge so a held request acts once
    always_comb begin
        w_state_nxt = r_state;
        o_wr_strobe = 1'b0;
        o_rd_strobe = 1'b0;
        case (r_state)
            BUS_IDLE: begin
                if (w_req) begin
                    w_state_nxt = BUS_ACK;
                    o_wr_strobe = io_write;
                    o_rd_strobe = io_read & ~io_write;
                end else begin
                    w_state_nxt = BUS_IDLE;
                end
            end
            BUS_ACK: begin
                if (w_req) begin
                    w_state_nxt = BUS_ACK;
                end else begin
                    w_state_nxt = BUS_IDLE;
                end
            end
            default: begin
                w_state_nxt = BUS_IDLE;
            end
        endcase
    end

    // Read buffer holds the register value sampled at the capture edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_buf <= {DATA_WIDTH{1'b0}};
        end else if (o_rd_strobe) begin
            r_rd_buf <= i_rd_data;
        end else begin
            r_rd_buf <= r_rd_buf;
        end
    end

    assign io_ready = (r_state == BUS_ACK);
    // A combined read+write is a write, so the bus is left to the master
    assign w_drive  = io_ready & io_read & ~io_write;
    assign io_data  = w_drive ? r_rd_buf : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/io_timer.sv
// Down-counting timer peripheral: CTRL/LOAD/COUNT/STATUS registers, 8-bit
// prescaler, sticky expiry flag and registered interrupt output.
module io_timer
    import io_timer_pkg::*;
#(
    parameter int DATA_WIDTH = PERIPH_DATA_WIDTH,
    parameter int ADDR_WIDTH = PERIPH_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    inout  wire  [DATA_WIDTH-1:0] io_data,
    input  logic                  io_read,
    input  logic                  io_write,
    output logic                  io_ready,
    output logic                  irq
);

    logic                  w_wr_strobe;
    logic                  w_rd_strobe;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_wr_ctrl;
    logic                  w_wr_load;
    logic                  w_wr_count;
    logic                  w_wr_status;

    logic                  r_en;
    logic                  r_auto;
    logic                  r_irq_en;
    logic [7:0]            r_presc;
    logic [7:0]            r_psc;
    logic [DATA_WIDTH-1:0] r_load;
    logic [DATA_WIDTH-1:0] r_count;
    logic                  r_expired;
    logic                  r_irq;

    logic                  w_tick;
    logic                  w_tick_eff;
    logic                  w_zero;
    logic                  w_expire;
    logic                  w_en_rise;

    io_timer_periph_bus_if #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bus (
        .clk         (clk),
        .rst         (rst),
        .io_read     (io_read),
        .io_write    (io_write),
        .io_data     (io_data),
        .io_ready    (io_ready),
        .o_wr_strobe (w_wr_strobe),
        .o_rd_strobe (w_rd_strobe),
        .i_rd_data   (w_rd_data)
    );

    assign w_wr_ctrl   = w_wr_strobe & (io_addr == ADDR_WIDTH'(TIMER_CTRL));
    assign w_wr_load   = w_wr_strobe & (io_addr == ADDR_WIDTH'(TIMER_LOAD));
    assign w_wr_count  = w_wr_strobe & (io_addr == ADDR_WIDTH'(TIMER_COUNT));
    assign w_wr_status = w_wr_strobe & (io_addr == ADDR_WIDTH'(TIMER_STATUS));

    assign w_tick     = r_en & (r_psc == r_presc);
    // A COUNT write or a CTRL write that drops EN overrides a coincident tick
    assign w_tick_eff = w_tick & ~(w_wr_ctrl & ~io_data[CTRL_EN_BIT]) & ~w_wr_count;
    assign w_zero     = (r_count == {DATA_WIDTH{1'b0}});
    assign w_expire   = w_tick_eff & w_zero;
    assign w_en_rise  = w_wr_ctrl & io_data[CTRL_EN_BIT] & ~r_en;

    // Register read mux; unlisted bits and indices read as zero
    always_comb begin
        w_rd_data = {DATA_WIDTH{1'b0}};
        case (io_addr)
            ADDR_WIDTH'(TIMER_CTRL): begin
                w_rd_data[CTRL_EN_BIT]                         = r_en;
                w_rd_data[CTRL_AUTO_BIT]                       = r_auto;
                w_rd_data[CTRL_IRQ_EN_BIT]                     = r_irq_en;
                w_rd_data[CTRL_PRESC_LSB +: CTRL_PRESC_WIDTH]  = r_presc;
            end
            ADDR_WIDTH'(TIMER_LOAD):   w_rd_data = r_load;
            ADDR_WIDTH'(TIMER_COUNT):  w_rd_data = r_count;
            ADDR_WIDTH'(TIMER_STATUS): w_rd_data[STATUS_EXPIRED_BIT] = r_expired;
            default:                   w_rd_data = {DATA_WIDTH{1'b0}};
        endcase
    end

    // CTRL fields; a one-shot expiry clears EN unless the bus writes CTRL that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_irq_en <= 1'b0;
            r_presc  <= 8'd0;
        end else if (w_wr_ctrl) begin
            r_en     <= io_data[CTRL_EN_BIT];
            r_auto   <= io_data[CTRL_AUTO_BIT];
            r_irq_en <= io_data[CTRL_IRQ_EN_BIT];
            r_presc  <= io_data[CTRL_PRESC_LSB +: CTRL_PRESC_WIDTH];
        end else if (w_expire & ~r_auto) begin
            r_en     <= 1'b0;
        end else begin
            r_en     <= r_en;
        end
    end

    // LOAD register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load <= {DATA_WIDTH{1'b0}};
        end else if (w_wr_load) begin
            r_load <= io_data;
        end else begin
            r_load <= r_load;
        end
    end

    // Prescaler runs 0..PRESC while enabled and restarts when EN is switched on
    always_ff @(posedge clk) begin
        if (rst) begin
            r_psc <= 8'd0;
        end else if (w_en_rise) begin
            r_psc <= 8'd0;
        end else if (r_en) begin
            r_psc <= w_tick ? 8'd0 : (r_psc + 8'd1);
        end else begin
            r_psc <= r_psc;
        end
    end

    // COUNT: direct write, else decrement per tick, reload or park at zero on expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {DATA_WIDTH{1'b0}};
        end else if (w_wr_count) begin
            r_count <= io_data;
        end else if (w_tick_eff) begin
            if (w_zero) begin
                r_count <= r_auto ? r_load : {DATA_WIDTH{1'b0}};
            end else begin
                r_count <= r_count - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            r_count <= r_count;
        end
    end

    // Sticky EXPIRED; a new expiry beats a simultaneous write-1-to-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_wr_status & io_data[STATUS_EXPIRED_BIT]) begin
            r_expired <= 1'b0;
        end else begin
            r_expired <= r_expired;
        end
    end

    // Interrupt line is a registered copy of EXPIRED gated by IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_expired & r_irq_en;
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_io_timer.sv
// Bench for io_timer: directed register table, hand-built timing sequences and
// randomized bus traffic, all checked cycle by cycle against a behavioural model.
module tb_io_timer;
    import io_timer_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] io_addr;
    wire  [DW-1:0] io_data;
    logic          io_read;
    logic          io_write;
    logic          io_ready;
    logic          irq;
    logic [DW-1:0] tb_wdata;

    assign io_data = io_write ? tb_wdata : {DW{1'bz}};

    always #5 clk = ~clk;

    io_timer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_data  (io_data),
        .io_read  (io_read),
        .io_write (io_write),
        .io_ready (io_ready),
        .irq      (irq)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model state
    bit          m_ack, m_en, m_auto, m_irqen, m_exp, m_irq;
    int unsigned m_presc, m_phase;
    logic [31:0] m_load, m_count, m_rdbuf;

    typedef struct {
        bit          wr;
        int          addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] reg_value(input int a);
        case (a)
            0:       return (32'(m_presc) << 8) | (32'(m_irqen) << 2) | (32'(m_auto) << 1) | 32'(m_en);
            1:       return m_load;
            2:       return m_count;
            3:       return 32'(m_exp);
            default: return 32'd0;
        endcase
    endfunction

    // One clock: advance the model by the register-map rules, then compare outputs
    task automatic step();
        bit commit, is_wr, is_rd, wc, wl, wn, ws, tick, tick_eff, expire, n_irq;
        int a;
        logic [31:0] d;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_ack = 0; m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0; m_irq = 0;
            m_presc = 0; m_phase = 0; m_load = 0; m_count = 0; m_rdbuf = 0;
        end else begin
            a = int'(io_addr);
            d = tb_wdata;
            commit = !m_ack && (io_read || io_write);
            is_wr  = commit && io_write;
            is_rd  = commit && io_read && !io_write;
            wc = is_wr && a == 0;
            wl = is_wr && a == 1;
            wn = is_wr && a == 2;
            ws = is_wr && a == 3;
            n_irq = m_exp && m_irqen;
            if (is_rd) m_rdbuf = reg_value(a);
            tick     = m_en && (m_phase == m_presc);
            tick_eff = tick && !(wc && !d[0]) && !wn;
            expire   = tick_eff && (m_count == 0);
            if (wc && d[0] && !m_en) m_phase = 0;
            else if (m_en)           m_phase = tick ? 0 : m_phase + 1;
            if (wn)            m_count = d;
            else if (tick_eff) m_count = (m_count == 0) ? (m_auto ? m_load : 32'd0) : m_count - 32'd1;
            if (expire)            m_exp = 1;
            else if (ws && d[0])   m_exp = 0;
            if (wc) begin
                m_en = d[0]; m_auto = d[1]; m_irqen = d[2]; m_presc = int'(d[15:8]);
            end else if (expire && !m_auto) begin
                m_en = 0;
            end
            if (wl) m_load = d;
            m_ack = commit ? 1'b1 : ((io_read || io_write) ? m_ack : 1'b0);
            m_irq = n_irq;
        end
        #1;
        check("io_ready", 32'(io_ready), 32'(m_ack));
        check("irq", 32'(irq), 32'(m_irq));
        if (m_ack && io_read && !io_write) check("rdata_model", io_data, m_rdbuf);
    endtask

    // Full handshake: request, optional extra hold cycles, release
    task automatic bus(input bit rd, input bit wr, input int a, input logic [31:0] d,
                       input int hold, output logic [31:0] rdata);
        io_read  = rd;
        io_write = wr;
        io_addr  = AW'(a);
        tb_wdata = d;
        step();
        rdata = io_data;
        for (int i = 0; i < hold; i++) step();
        io_read  = 1'b0;
        io_write = 1'b0;
        step();
    endtask

    task automatic wr_reg(input int a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b0, 1'b1, a, d, 0, dummy);
    endtask

    task automatic rd_check(input string name, input int a, input logic [31:0] exp, input int hold);
        logic [31:0] r;
        bus(1'b1, 1'b0, a, 32'd0, hold, r);
        check(name, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        int c0;
        logic [31:0] seq_exp [4];

        rst = 1'b1; io_read = 1'b0; io_write = 1'b0; io_addr = '0; tb_wdata = 32'd0;
        step(); step();
        rst = 1'b0;
        step();

        // Directed register table, timer disabled so values are static
        tbl[0]  = '{1'b0, 0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 1, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 2, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 3, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 1, 32'hDEADBEEF, 32'h0};
        tbl[5]  = '{1'b0, 1, 32'h0,        32'hDEADBEEF};
        tbl[6]  = '{1'b1, 0, 32'hFFFFFF06, 32'h0};
        tbl[7]  = '{1'b0, 0, 32'h0,        32'h0000FF06};
        tbl[8]  = '{1'b1, 2, 32'h7,        32'h0};
        tbl[9]  = '{1'b0, 2, 32'h0,        32'h7};
        tbl[10] = '{1'b1, 5, 32'h1234,     32'h0};
        tbl[11] = '{1'b0, 5, 32'h0,        32'h0};
        tbl[12] = '{1'b1, 3, 32'h1,        32'h0};
        tbl[13] = '{1'b0, 3, 32'h0,        32'h0};
        tbl[14] = '{1'b1, 0, 32'h0,        32'h0};
        tbl[15] = '{1'b0, 0, 32'h0,        32'h0};
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) wr_reg(tbl[i].addr, tbl[i].wdata);
            else           rd_check($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp, 0);
        end

        // Auto-reload, PRESC=0: COUNT cycles 3,2,1,0,3...; reads every 3 clocks
        wr_reg(1, 32'd3);
        wr_reg(2, 32'd3);
        wr_reg(0, 32'h3);
        seq_exp[0] = 32'd2; seq_exp[1] = 32'd3; seq_exp[2] = 32'd0; seq_exp[3] = 32'd1;
        for (int i = 0; i < 4; i++) rd_check($sformatf("auto_count%0d", i), 2, seq_exp[i], 1);
        rd_check("auto_expired", 3, 32'd1, 0);
        wr_reg(0, 32'h0);

        // One-shot LOAD/COUNT=5, PRESC=2: EXPIRED after 18 clocks, irq one later
        wr_reg(3, 32'd1);
        wr_reg(2, 32'd5);
        wr_reg(1, 32'd5);
        io_write = 1'b1; io_addr = AW'(0); tb_wdata = 32'h0205;
        step();
        c0 = cyc;
        io_write = 1'b0;
        step();
        while (irq !== 1'b1 && (cyc - c0) < 40) step();
        check("oneshot_irq_latency", 32'(cyc - c0), 32'd19);
        rd_check("oneshot_ctrl", 0, 32'h0204, 0);
        rd_check("oneshot_count", 2, 32'd0, 0);
        repeat (6) step();
        rd_check("oneshot_count_hold", 2, 32'd0, 0);
        rd_check("oneshot_status", 3, 32'd1, 0);

        // STATUS clear on the same edge as an expiry: set wins
        wr_reg(3, 32'd1);
        wr_reg(0, 32'h0);
        wr_reg(2, 32'd2);
        io_write = 1'b1; io_addr = AW'(0); tb_wdata = 32'h5;
        step();
        io_write = 1'b0;
        step();
        step();
        io_write = 1'b1; io_addr = AW'(3); tb_wdata = 32'h1;
        step();
        io_write = 1'b0;
        step();
        rd_check("clear_vs_expiry", 3, 32'd1, 0);
        io_write = 1'b1; io_addr = AW'(3); tb_wdata = 32'h1;
        step();
        check("irq_before_fall", 32'(irq), 32'd1);
        io_write = 1'b0;
        step();
        check("irq_after_fall", 32'(irq), 32'd0);
        rd_check("status_cleared", 3, 32'd0, 0);

        // Held write to COUNT on a running timer commits once
        wr_reg(1, 32'd100);
        wr_reg(0, 32'h3);
        io_write = 1'b1; io_addr = AW'(2); tb_wdata = 32'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_ready", 32'(io_ready), 32'd1);
        end
        io_write = 1'b0;
        step();
        check("hold_release", 32'(io_ready), 32'd0);
        io_read = 1'b1; io_addr = AW'(2);
        step();
        check("hold_single_commit", io_data, 32'd2);
        io_read = 1'b0;
        step();
        rd_check("index5_read", 5, 32'd0, 2);

        // Reset in the middle of an access, request still held
        io_read = 1'b1; io_addr = AW'(2);
        step();
        rst = 1'b1;
        step();
        check("rst_ready_low", 32'(io_ready), 32'd0);
        check("rst_irq_low", 32'(irq), 32'd0);
        rst = 1'b0;
        step();
        check("rst_reserve_ready", 32'(io_ready), 32'd1);
        check("rst_reserve_data", io_data, 32'd0);
        io_read = 1'b0;
        step();
        for (int i = 0; i < 4; i++) rd_check($sformatf("rst_reg%0d", i), i, 32'd0, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            int a, kind, hold;
            logic [31:0] d;
            a    = $urandom_range(0, 5);
            kind = $urandom_range(0, 9);
            hold = $urandom_range(0, 3);
            case (a)
                0:       d = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 7));
                1, 2:    d = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 6));
                3:       d = 32'($urandom_range(0, 1));
                default: d = $urandom;
            endcase
            if (kind < 5)      bus(1'b1, 1'b0, a, d, hold, r);
            else if (kind < 9) bus(1'b0, 1'b1, a, d, hold, r);
            else               bus(1'b1, 1'b1, a, d, hold, r);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
